// File: rtl/mem_line_pkg.sv
// Purpose: shared types for the cache-line transfer engine.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_line_pkg;

   // Engine sequencing: accept a line request, then ISSUE/WAIT once per word, then FIN.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FIN   = 2'd3
   } line_state_t;

endpackage

// File: rtl/mem_line_engine.sv
// Purpose: splits one cache-line fill/writeback into WORDS_PER_LINE single-word WB master ops.
// Latency: sum of per-word WB latencies (each plus 1 ISSUE cycle) + 2 (accept, FIN).
// Backpressure: requests are taken only in IDLE; while busy_o is high, req_* are ignored.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_rd_i, req_wr_i     line fill / line writeback request (write wins when both are high)
//   line_addr_i, wline_i   line address (offset bits ignored), writeback line
//   busy_o, done_o         engine active, one-cycle completion pulse
//   rline_o                assembled fill line (word k at [k*DATA_WIDTH +: DATA_WIDTH])
//   start_rd_o/start_wr_o  single-word start pulses to the WB master
//   sel_o, data_o, addr_o  byte selects, write word, word byte address to the WB master
//   done_i, data_i         word completion pulse and read word from the WB master
module mem_line_engine
   import mem_line_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 req_rd_i,
   input  logic                                 req_wr_i,
   input  logic [ADDR_WIDTH-1:0]                line_addr_i,
   input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] wline_i,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] rline_o,
   output logic                                 start_rd_o,
   output logic                                 start_wr_o,
   output logic [DATA_WIDTH/8-1:0]              sel_o,
   output logic [DATA_WIDTH-1:0]                data_o,
   output logic [ADDR_WIDTH-1:0]                addr_o,
   input  logic                                 done_i,
   input  logic [DATA_WIDTH-1:0]                data_i
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BOFS  = $clog2(BYTES);
   localparam int CW    = $clog2(WORDS_PER_LINE);
   localparam int OFS   = CW + BOFS;
   localparam int LW    = DATA_WIDTH * WORDS_PER_LINE;
   localparam logic [CW-1:0] LAST = CW'(WORDS_PER_LINE - 1);

   line_state_t           r_state;
   line_state_t           w_next;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [CW-1:0]         r_cnt;
   logic                  r_wr;
   logic [LW-1:0]         r_wline;
   logic [LW-1:0]         r_rline;
   logic                  w_req;

   assign w_req = req_wr_i | req_rd_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state plus the control outputs, all decoded from registered state.
   always_comb begin
      w_next     = r_state;
      busy_o     = 1'b1;
      done_o     = 1'b0;
      start_rd_o = 1'b0;
      start_wr_o = 1'b0;
      case (r_state)
         IDLE: begin
            busy_o = 1'b0;
            if (w_req) w_next = ISSUE;
         end
         ISSUE: begin
            start_wr_o = r_wr;
            start_rd_o = ~r_wr;
            w_next     = WAIT;
         end
         WAIT: begin
            if (done_i) w_next = (r_cnt == LAST) ? FIN : ISSUE;
         end
         FIN: begin
            done_o = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_base  <= '0;
         r_cnt   <= '0;
         r_wr    <= 1'b0;
         r_wline <= '0;
         r_rline <= '0;
      end else if (r_state == IDLE && w_req) begin
         r_base  <= {line_addr_i[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
         r_wline <= wline_i;
         r_wr    <= req_wr_i;
         r_cnt   <= '0;
      end else if (r_state == WAIT && done_i) begin
         if (!r_wr) r_rline[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= data_i;
         // Counter stops at the last word so it never wraps inside a line.
         if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
      end
   end

   // Base has zero offset bits, so OR-ing in the word index keeps the carry inside the line.
   assign addr_o  = r_base | (ADDR_WIDTH'(r_cnt) << BOFS);
   assign data_o  = r_wline[r_cnt*DATA_WIDTH +: DATA_WIDTH];
   assign sel_o   = busy_o ? '1 : '0;
   assign rline_o = r_rline;

endmodule
